// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padder.
// Block geometry follows the 512-bit SHA-256 message block.
package sha256_pkg;

  typedef enum logic [1:0] {FILL, PAD, LEN, SEND} pad_state_t;

  localparam int BLOCK_BYTES     = 64;
  localparam int LEN_OFFSET      = 56;
  localparam int WORDS_PER_BLOCK = 16;
  localparam logic [7:0] PAD_BYTE = 8'h80;

endpackage

// File: rtl/sha256_msg_padder.sv
// Streams an arbitrary-length byte message into padded 512-bit SHA-256 blocks,
// emitted as 16 big-endian words with valid/ready backpressure.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int IN_BYTES = 16,
  parameter int CNT_W    = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IN_BYTES*8-1:0]        in_data,
  input  logic [$clog2(IN_BYTES+1)-1:0] in_nbytes,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_word,
  output logic                         out_sob,
  output logic                         out_eob,
  output logic                         out_eom,
  output logic                         proto_err
);

  // Handshake rule for both ports: a transfer happens on a rising clk edge
  // where valid and ready are both 1; the producer holds data/flags stable
  // while valid=1 and ready=0, and ready never depends on valid.

  pad_state_t       state, state_d;
  logic [6:0]       wr_ptr;
  logic [CNT_W-1:0] len;
  logic [63:0]      len64;
  logic [3:0]       send_cnt;
  logic             pad_pend, len_pend, final_q;
  logic [7:0]       blk_buf [BLOCK_BYTES];

  logic [7:0]       nb_ext;
  logic [7:0]       wr_ptr_sum;
  logic             beat_fire, beat_bad, word_fire, last_word;

  assign nb_ext     = 8'(in_nbytes);
  assign wr_ptr_sum = {1'b0, wr_ptr} + nb_ext;
  assign len64      = 64'(len);
  assign beat_fire  = in_valid && (state == FILL);
  assign beat_bad   = (nb_ext > 8'(IN_BYTES)) ||
                      (!in_last && (nb_ext != 8'(IN_BYTES)));
  assign word_fire  = (state == SEND) && out_ready;
  assign last_word  = (send_cnt == 4'(WORDS_PER_BLOCK - 1));

  always_ff @(posedge clk) begin
    if (!rst) state <= FILL;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      FILL: begin
        if (beat_fire && !beat_bad) begin
          if (wr_ptr_sum == 8'(BLOCK_BYTES)) state_d = SEND;
          else if (in_last)                  state_d = PAD;
        end
      end
      PAD:  state_d = SEND;
      LEN:  state_d = SEND;
      SEND: begin
        if (word_fire && last_word) begin
          if (pad_pend)      state_d = PAD;
          else if (len_pend) state_d = LEN;
          else               state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    in_ready  = (state == FILL);
    out_valid = (state == SEND);
    out_word  = 32'h0;
    out_sob   = 1'b0;
    out_eob   = 1'b0;
    out_eom   = 1'b0;
    if (out_valid) begin
      out_word = {blk_buf[{send_cnt, 2'd0}], blk_buf[{send_cnt, 2'd1}],
                  blk_buf[{send_cnt, 2'd2}], blk_buf[{send_cnt, 2'd3}]};
      out_sob  = (send_cnt == 4'd0);
      out_eob  = last_word;
      out_eom  = final_q;
    end
  end

  // Control and length bookkeeping; the buffer itself needs no reset since
  // it is always fully rewritten before a block is sent.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr    <= '0;
      len       <= '0;
      send_cnt  <= '0;
      pad_pend  <= 1'b0;
      len_pend  <= 1'b0;
      final_q   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      proto_err <= 1'b0;
      case (state)
        FILL: begin
          if (beat_fire) begin
            if (beat_bad) begin
              proto_err <= 1'b1;
            end else begin
              wr_ptr <= wr_ptr_sum[6:0];
              len    <= len + (CNT_W'(in_nbytes) << 3);
              if (wr_ptr_sum == 8'(BLOCK_BYTES)) pad_pend <= in_last;
            end
          end
        end
        PAD: begin
          final_q  <= (wr_ptr <= 7'(LEN_OFFSET - 1));
          len_pend <= (wr_ptr >= 7'(LEN_OFFSET));
        end
        LEN: final_q <= 1'b1;
        SEND: begin
          if (word_fire) begin
            send_cnt <= send_cnt + 4'd1;
            if (last_word) begin
              if (pad_pend) begin
                wr_ptr   <= '0;
                pad_pend <= 1'b0;
              end else if (len_pend) begin
                len_pend <= 1'b0;
              end else if (final_q) begin
                len     <= '0;
                wr_ptr  <= '0;
                final_q <= 1'b0;
              end else begin
                wr_ptr <= '0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      case (state)
        FILL: begin
          if (beat_fire && !beat_bad) begin
            for (int i = 0; i < IN_BYTES; i++) begin
              if (i < int'(in_nbytes))
                blk_buf[wr_ptr[5:0] + 6'(i)] <= in_data[(IN_BYTES-1-i)*8 +: 8];
            end
          end
        end
        PAD: begin
          // Length lands here only when it fits behind the 0x80 marker.
          for (int i = 0; i < BLOCK_BYTES; i++) begin
            if (7'(i) == wr_ptr)
              blk_buf[i] <= PAD_BYTE;
            else if (7'(i) > wr_ptr) begin
              if (i >= LEN_OFFSET && wr_ptr <= 7'(LEN_OFFSET - 1))
                blk_buf[i] <= len64[8*(BLOCK_BYTES-1-i) +: 8];
              else
                blk_buf[i] <= 8'h00;
            end
          end
        end
        LEN: begin
          for (int i = 0; i < BLOCK_BYTES; i++) begin
            if (i >= LEN_OFFSET) blk_buf[i] <= len64[8*(BLOCK_BYTES-1-i) +: 8];
            else                 blk_buf[i] <= 8'h00;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: reference FIPS padding model feeds an
// expected-word queue that a negedge monitor drains and compares.
module tb_sha256_msg_padder;
  import sha256_pkg::*;

  localparam int IN_BYTES = 16;
  localparam int CNT_W    = 64;
  localparam int NB_W     = $clog2(IN_BYTES+1);

  logic                  clk;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [IN_BYTES*8-1:0] in_data;
  logic [NB_W-1:0]       in_nbytes;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_word;
  logic                  out_sob, out_eob, out_eom;
  logic                  proto_err;

  int n_vec = 0;
  int n_err = 0;
  logic [34:0] exp_q[$];
  logic [7:0]  msg[$];
  logic        rand_ready = 1'b0;

  sha256_msg_padder #(.IN_BYTES(IN_BYTES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_nbytes(in_nbytes), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_sob(out_sob), .out_eob(out_eob), .out_eom(out_eom),
    .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: pops one expectation per handshake and checks hold-stability.
  logic        hold_v = 1'b0;
  logic [34:0] hold_w;
  logic [34:0] obs_w;
  always @(negedge clk) begin
    obs_w = {out_sob, out_eob, out_eom, out_word};
    if (rst) begin
      if (hold_v && out_valid) check("hold_stable", 64'(obs_w), 64'(hold_w));
      if (out_valid && out_ready) begin
        n_vec++;
        assert (exp_q.size() > 0) else begin
          n_err++;
          $error("FAIL extra_word obs=%0h exp=none", obs_w);
        end
        if (exp_q.size() > 0) check("word", 64'(obs_w), 64'(exp_q.pop_front()));
        hold_v = 1'b0;
      end else begin
        hold_v = out_valid;
        hold_w = obs_w;
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  // Reference padding: append 0x80, zero-fill to 56 mod 64, append bit length.
  task automatic push_expected();
    logic [7:0]  p[$];
    logic [63:0] bitlen;
    int          nblk;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bitlen = 64'(msg.size()) * 64'd8;
    for (int k = 7; k >= 0; k--) p.push_back(bitlen[8*k +: 8]);
    nblk = p.size() / 64;
    for (int w = 0; w < p.size() / 4; w++)
      exp_q.push_back({(w % 16 == 0), (w % 16 == 15), (w / 16 == nblk - 1),
                       p[4*w], p[4*w+1], p[4*w+2], p[4*w+3]});
  endtask

  task automatic drive_beat(input logic [IN_BYTES*8-1:0] d, input int nb, input logic last);
    int t;
    t = 0;
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    in_data   = d;
    in_nbytes = NB_W'(nb);
    in_last   = last;
    @(negedge clk);
    while (!in_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("beat_accept", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic send_msg();
    int off, rem, nb;
    logic last;
    logic [IN_BYTES*8-1:0] d;
    push_expected();
    off = 0;
    do begin
      rem  = msg.size() - off;
      nb   = (rem < IN_BYTES) ? rem : IN_BYTES;
      last = (rem <= IN_BYTES);
      d    = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < nb; i++) d[(IN_BYTES-1-i)*8 +: 8] = msg[off+i];
      drive_beat(d, nb, last);
      off += nb;
    end while (!last);
  endtask

  task automatic rand_msg(input int n);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic abc_msg();
    msg.delete();
    msg.push_back(8'h61);
    msg.push_back(8'h62);
    msg.push_back(8'h63);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_nbytes = '0;
    in_last   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_word", 64'(out_word), 64'd0);
    check("rst_flags", 64'({out_sob, out_eob, out_eom}), 64'd0);
    check("rst_proto_err", 64'(proto_err), 64'd0);

    // "abc": first word two cycles after the last beat (through PAD).
    abc_msg();
    send_msg();
    @(negedge clk);
    check("abc_pad_cycle_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("abc_first_word_valid", 64'(out_valid), 64'd1);
    check("abc_first_word", 64'(out_word), 64'h61626380);
    wait_drain();

    // Boundary lengths around the 56-byte length slot and a full block.
    rand_msg(55);  send_msg(); wait_drain();
    rand_msg(56);  send_msg(); wait_drain();
    rand_msg(64);  send_msg(); wait_drain();
    rand_msg(120); send_msg(); wait_drain();

    // Backpressure from the engine.
    rand_ready = 1'b1;
    msg.delete();
    send_msg();
    wait_drain();
    rand_msg(119); send_msg(); wait_drain();
    rand_ready = 1'b0;
    @(negedge clk);

    // Illegal beats are dropped with a one-cycle error pulse.
    drive_beat({$urandom, $urandom, $urandom, $urandom}, 5, 1'b0);
    check("perr_short_nonlast", 64'(proto_err), 64'd1);
    check("perr_no_output", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("perr_pulse_end", 64'(proto_err), 64'd0);
    drive_beat({$urandom, $urandom, $urandom, $urandom}, IN_BYTES + 1, 1'b1);
    check("perr_oversize", 64'(proto_err), 64'd1);
    check("perr_in_ready", 64'(in_ready), 64'd1);
    abc_msg();
    send_msg();
    wait_drain();

    // Reset while word 7 of a block is on the output.
    abc_msg();
    send_msg();
    repeat (8) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b1;
    abc_msg();
    send_msg();
    wait_drain();

    repeat (4) @(negedge clk);
    check("end_idle", 64'(out_valid), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
- Parametrised successor to the single-block SHA-256 preprocessor.
- Accepts an arbitrary-length byte message as a stream of beats with valid/ready handshake.
- Performs full FIPS 180-4 padding across multiple 512-bit blocks, including the extra block when the 0x80 byte and 64-bit length do not fit.
- Emits each block as 16 big-endian 32-bit words, with backpressure, to the SHA-256 compression engine.

Parameters:
- IN_BYTES, 16, bytes per input beat; power of two, 4..64 (must divide 64).
- CNT_W, 64, internal message-length counter width in bits, 16..64; zero-extended to 64 in the length field; wraps modulo 2^CNT_W.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  padder can accept a beat
- in_data  in  IN_BYTES*8  message bytes; byte 0 in bits [IN_BYTES*8-1 -: 8]
- in_nbytes  in  $clog2(IN_BYTES+1)  valid bytes in the beat, from byte 0
- in_last  in  1  final beat of the message
- out_valid  out  1  out_word valid
- out_ready  in  1  engine accepts the word
- out_word  out  32  block word, big-endian (byte 4i in [31:24])
- out_sob  out  1  word index 0 of a block
- out_eob  out  1  word index 15 of a block
- out_eom  out  1  block is the final block of the message (valid with out_valid)
- proto_err  out  1  one-cycle pulse: illegal beat dropped

Behaviour:
- Reset (rst=0 at clk edge): state FILL, wr_ptr=0, len=0, send_cnt=0, all flags 0. Outputs: out_valid=0, out_sob/eob/eom=0, proto_err=0, out_word=0, in_ready=1 on the first cycle after reset. Reset mid-operation aborts the message; no partial block is emitted.
- Block buffer: 64 bytes; wr_ptr is 7 bits (0..64).
- State FILL (in_ready=1; out_valid=0). On in_valid&&in_ready:
  - !in_last and in_nbytes!=IN_BYTES: beat dropped, proto_err=1, no state change.
  - in_nbytes>IN_BYTES: same as above (dropped, proto_err=1).
  - Otherwise: bytes 0..in_nbytes-1 are written at wr_ptr; wr_ptr+=in_nbytes; len+=in_nbytes*8.
  - New wr_ptr==64: go to SEND; pad_pend=in_last.
  - Else if in_last: go to PAD.
  - A last beat with in_nbytes=0 is legal (covers the empty message).
- State PAD (1 cycle, in_ready=0):
  - buf[wr_ptr]=0x80; bytes wr_ptr+1..63 cleared.
  - wr_ptr<=55: buf[56..63]=len (zero-extended to 64 bits, big-endian); final=1.
  - wr_ptr>=56: len_pend=1; final=0.
  - Then go to SEND.
- State LEN (1 cycle, in_ready=0): buf[0..55]=0; buf[56..63]=len; final=1; go to SEND.
- State SEND (in_ready=0; out_valid=1):
  - out_word = buf[4*send_cnt .. 4*send_cnt+3].
  - out_sob = (send_cnt==0); out_eob = (send_cnt==15); out_eom = final.
  - Advance on out_valid&&out_ready only. out_word and flags are held stable while out_ready=0.
- After the word-15 handshake, in priority order:
  - pad_pend: wr_ptr=0, pad_pend=0, go to PAD (the 0x80 goes at byte 0).
  - len_pend: len_pend=0, go to LEN.
  - final: len=0, wr_ptr=0, final=0, go to FILL.
  - Otherwise: wr_ptr=0, go to FILL (mid-message block).
- Latency and throughput:
  - First word appears 1 cycle after the beat that completes the block.
  - For the final partial block, the first word appears 2 cycles after the in_last beat (through PAD).
  - Sustained output: 1 word/cycle with out_ready=1.
  - Input is stalled for the 16+ cycles of SEND; no double buffering.
- Simultaneous events: a reset during a handshake wins; the beat is lost.
- Length wrap: the counter wraps silently; no error is raised.

Decomposition:
- sha256_pkg holds:
  - typedef enum logic [1:0] {FILL, PAD, LEN, SEND} pad_state_t
  - localparam BLOCK_BYTES=64, LEN_OFFSET=56, WORDS_PER_BLOCK=16, PAD_BYTE=8'h80
- Single module; no sub-module (the buffer and mux are too small to justify one).

Test Plan:
- "abc" (IN_BYTES=16, one beat, nbytes=3, last) -> 16 words: 0x61626380, then zeros, word14=0, word15=0x00000018; sob on word 0, eob on word 15, eom=1.
- 55-byte message (3 full beats + 7-byte last) -> one block; byte 55=0x80; word15=0x000001B8; eom=1.
- 56-byte message -> two blocks: block 1 has 0x80 at byte 56 and eom=0; block 2 is all zero except word15=0x000001C0, eom=1.
- 64-byte message (4 beats, last full) -> block 1 is data with eom=0; block 2 has word0=0x80000000 and word15=0x00000200, eom=1.
- Empty message (nbytes=0, last) -> word0=0x80000000, rest 0, word15=0; then out_ready toggled randomly -> words held stable and none skipped; a non-last 5-byte beat -> proto_err pulse and buffer unchanged.
- rst=0 during SEND word 7 -> next cycle out_valid=0, in_ready=1; a following "abc" yields a correct single block.
